// File: rtl/truth_table_sweeper_if.sv
// Stimulus/capture bundle between a truth-table sweeper and whoever starts it
// and supplies the combinational response y.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN = 3
);
  logic                   start;
  logic [N_IN-1:0]        stim;
  logic                   y;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [(2**N_IN)-1:0]   table_out;
  logic [N_IN:0]          err_count;
  logic [N_IN-1:0]        first_err;

  // Controller/response side: requests sweeps and closes the loop on y.
  modport master (
    output start, y,
    input  stim, busy, done, pass, table_out, err_count, first_err
  );

  modport slave (
    input  start, y,
    output stim, busy, done, pass, table_out, err_count, first_err
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector into a combinational circuit, captures its one-bit
// response per vector and grades the resulting truth table against EXPECTED.
module truth_table_sweeper #(
  parameter int unsigned            N_IN     = 3,
  parameter int unsigned            HOLD     = 4,
  parameter logic [(2**N_IN)-1:0]   EXPECTED = 8'b1001_0110
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave bus
);

  localparam int unsigned NVec  = 2 ** N_IN;
  localparam int unsigned HoldW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned ErrW  = N_IN + 1;

  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD - 1);
  localparam logic [N_IN-1:0]  IdxMax  = N_IN'(NVec - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [NVec-1:0]   table_out_q, table_out_d;
  logic [ErrW-1:0]   err_count_q, err_count_d;
  logic [N_IN-1:0]   first_err_q, first_err_d;
  logic              mismatch;

  assign mismatch = (bus.y != EXPECTED[idx_q]);

  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    idx_d       = idx_q;
    hold_cnt_d  = hold_cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    table_out_d = table_out_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d     = StRun;
          busy_d      = 1'b1;
          idx_d       = '0;
          stim_d      = '0;
          hold_cnt_d  = '0;
          table_out_d = '0;
          err_count_d = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
        end
      end
      StRun: begin
        if (hold_cnt_q != HoldMax) begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end else begin
          hold_cnt_d         = '0;
          table_out_d[idx_q] = bus.y;
          if (mismatch) begin
            err_count_d = err_count_q + ErrW'(1);
            if (err_count_q == '0) first_err_d = idx_q;
          end
          if (idx_q != IdxMax) begin
            idx_d  = idx_q + N_IN'(1);
            stim_d = stim_q + N_IN'(1);
          end else begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stim_d  = '0;
            // Grade on the updated count so the last vector's miss is included.
            pass_d  = (err_count_d == '0);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        done_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      stim_q      <= '0;
      idx_q       <= '0;
      hold_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      table_out_q <= '0;
      err_count_q <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      idx_q       <= idx_d;
      hold_cnt_q  <= hold_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      table_out_q <= table_out_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
    end
  end

  assign bus.stim      = stim_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.table_out = table_out_q;
  assign bus.err_count = err_count_q;
  assign bus.first_err = first_err_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: a HOLD=4 sweeper and a HOLD=1 sweeper, each closing the loop
// through a selectable reference circuit (xor, majority, stuck-at-1).
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;
  int   mode;   // 0 = xor3, 1 = majority, 2 = stuck at 1
  int   n_asrt;
  int   n_fail;

  truth_table_sweeper_if #(.N_IN(3)) bus_a ();
  truth_table_sweeper_if #(.N_IN(3)) bus_b ();

  truth_table_sweeper #(.N_IN(3), .HOLD(4), .EXPECTED(8'b1001_0110)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  truth_table_sweeper #(.N_IN(3), .HOLD(1), .EXPECTED(8'b1001_0110)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  function automatic logic circuit_y(input logic [2:0] s, input int m);
    logic a, b, c;
    a = s[2];
    b = s[1];
    c = s[0];
    case (m)
      0:       return a ^ b ^ c;
      1:       return (a & b) | (a & c) | (b & c);
      default: return 1'b1;
    endcase
  endfunction

  assign bus_a.y = circuit_y(bus_a.stim, mode);
  assign bus_b.y = circuit_y(bus_b.stim, mode);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " stim"},  32'(bus_a.stim), 32'h0);
    check({tag, " busy"},  32'(bus_a.busy), 32'h0);
    check({tag, " done"},  32'(bus_a.done), 32'h0);
    check({tag, " pass"},  32'(bus_a.pass), 32'h0);
    check({tag, " table"}, 32'(bus_a.table_out), 32'h0);
    check({tag, " err"},   32'(bus_a.err_count), 32'h0);
    check({tag, " first"}, 32'(bus_a.first_err), 32'h0);
  endtask

  // Full HOLD=4 sweep on instance A; start is re-pulsed at edge pulse_at (0 = never).
  task automatic run_sweep(input string tag, input logic [7:0] exp_tab,
                           input logic [3:0] exp_err, input logic [2:0] exp_first,
                           input logic exp_pass, input int pulse_at);
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    check({tag, " accept busy"}, 32'(bus_a.busy), 32'h1);
    check({tag, " accept stim"}, 32'(bus_a.stim), 32'h0);
    check({tag, " cleared pass"}, 32'(bus_a.pass), 32'h0);
    check({tag, " cleared err"}, 32'(bus_a.err_count), 32'h0);
    check({tag, " cleared table"}, 32'(bus_a.table_out), 32'h0);
    for (int e = 1; e <= 31; e++) begin
      bus_a.start = (e == pulse_at);
      tick();
      check({tag, " run busy"}, 32'(bus_a.busy), 32'h1);
      check({tag, " run done"}, 32'(bus_a.done), 32'h0);
      if (e % 4 == 0) check({tag, " stim step"}, 32'(bus_a.stim), 32'(e / 4));
    end
    bus_a.start = 1'b0;
    tick();
    check({tag, " done pulse"}, 32'(bus_a.done), 32'h1);
    check({tag, " busy drop"}, 32'(bus_a.busy), 32'h0);
    check({tag, " stim park"}, 32'(bus_a.stim), 32'h0);
    check({tag, " table"}, 32'(bus_a.table_out), 32'(exp_tab));
    check({tag, " err"}, 32'(bus_a.err_count), 32'(exp_err));
    check({tag, " first"}, 32'(bus_a.first_err), 32'(exp_first));
    check({tag, " pass"}, 32'(bus_a.pass), 32'(exp_pass));
    tick();
    check({tag, " done low"}, 32'(bus_a.done), 32'h0);
    check({tag, " table held"}, 32'(bus_a.table_out), 32'(exp_tab));
    check({tag, " pass held"}, 32'(bus_a.pass), 32'(exp_pass));
    tick();
    check({tag, " idle no restart"}, 32'(bus_a.busy), 32'h0);
  endtask

  initial begin
    n_asrt      = 0;
    n_fail      = 0;
    mode        = 0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    rst_n       = 1'b0;
    #2;
    check_reset_state("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    mode = 0;
    run_sweep("xor", 8'h96, 4'd0, 3'd0, 1'b1, 0);

    mode = 1;
    run_sweep("maj", 8'hE8, 4'd6, 3'd1, 1'b0, 0);

    mode = 0;
    run_sweep("restart_ignored", 8'h96, 4'd0, 3'd0, 1'b1, 10);

    // Abort a sweep partway through with an asynchronous reset.
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int e = 1; e <= 13; e++) tick();
    check("midreset pre busy", 32'(bus_a.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    tick();
    tick();
    check("midreset no done", 32'(bus_a.done), 32'h0);
    rst_n = 1'b1;
    tick();
    check("midreset idle", 32'(bus_a.busy), 32'h0);
    run_sweep("after_reset", 8'h96, 4'd0, 3'd0, 1'b1, 0);

    // HOLD=1 instance, start held for 25 edges: back-to-back sweeps.
    mode        = 0;
    bus_b.start = 1'b1;
    tick();
    check("h1 accept busy", 32'(bus_b.busy), 32'h1);
    for (int e = 1; e <= 30; e++) begin
      if (e == 25) bus_b.start = 1'b0;
      tick();
      check("h1 done timing", 32'(bus_b.done), 32'((e == 8) || (e == 18) || (e == 28)));
      if ((e == 8) || (e == 18) || (e == 28)) begin
        check("h1 pass", 32'(bus_b.pass), 32'h1);
        check("h1 table", 32'(bus_b.table_out), 32'h96);
      end
      if (e == 3) check("h1 stim", 32'(bus_b.stim), 32'h3);
      if (e == 9) check("h1 idle gap", 32'(bus_b.busy), 32'h0);
      if (e == 10) check("h1 reaccept", 32'(bus_b.busy), 32'h1);
    end
    check("h1 final idle", 32'(bus_b.busy), 32'h0);

    mode = 2;
    run_sweep("stuck1", 8'hFF, 4'd4, 3'd0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Stimulus-and-capture stage that wraps the combinational lab circuits (work6-style a,b,c -> y).
- Upstream side: sweeps every input vector 0 .. 2**N_IN-1 into the device under test, holding each vector for HOLD clocks.
- Downstream side: samples the single-bit response y for each vector and assembles the full truth table.
- Result: compares the table against EXPECTED and reports pass/fail, error count and first failing index.
- Lets the hand-written vector lists in our benches be replaced by one reusable synthesizable block.

Parameters:
- N_IN, 3, number of DUT inputs; stim[N_IN-1] drives a, stim[0] drives c.
- HOLD, 4, clocks each vector is held; legal range >= 1.
- EXPECTED, 8'b1001_0110, golden truth table, width 2**N_IN; bit i is the expected y for input vector i.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- stim  out  N_IN  registered vector to the DUT; MSB = a.
- y  in  1  DUT response, combinational from stim.
- busy  out  1  high while vectors are being driven.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  high when err_count == 0 at the last completion; held until the next start or reset.
- table_out  out  2**N_IN  captured truth table; bit i = sampled y for vector i.
- err_count  out  N_IN+1  number of mismatching vectors.
- first_err  out  N_IN  lowest mismatching index; 0 when err_count == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n). Everything else is synchronous to the rising edge of clk.
- Reset values: state=IDLE, stim=0, busy=0, done=0, pass=0, table_out=0, err_count=0, first_err=0, idx=0, hold_cnt=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on an edge with start=1.
  - Same edge sets busy=1, idx=0, stim=0, hold_cnt=0.
  - Same edge clears table_out, err_count, first_err and pass.
- RUN, hold: hold_cnt increments every clock while hold_cnt < HOLD-1.
- RUN, sample edge (hold_cnt == HOLD-1):
  - table_out[idx] <= y.
  - If y != EXPECTED[idx]: err_count increments; first_err <= idx when err_count was 0.
  - hold_cnt <= 0.
  - If idx < 2**N_IN-1: idx and stim increment on the same edge, so the new vector is visible in the next cycle.
  - If idx == 2**N_IN-1: go to DONE.
- RUN -> DONE edge: busy <= 0, done <= 1, stim <= 0, pass <= (final error count == 0), including the last vector's mismatch.
- DONE -> IDLE: unconditional after one cycle; done <= 0.
- Latency: busy is high for exactly 2**N_IN * HOLD cycles. done rises 2**N_IN * HOLD edges after the start-accept edge.
- start handling:
  - start in RUN or DONE is ignored; there is no queuing.
  - start held high continuously gives back-to-back sweeps separated by one DONE and one IDLE cycle.
- Results: table_out, err_count, first_err and pass stay stable in IDLE until the next accepted start. table_out updates bit-by-bit during RUN.
- err_count cannot overflow: its maximum is 2**N_IN, which fits in N_IN+1 bits.
- HOLD=1: every edge in RUN is a sample edge.
- Reset mid-sweep: asserting rst_n low forces all reset values immediately. No done pulse is produced and the partial table is discarded.

Test Plan:
1. Default parameters, DUT = 3-input XOR (y=a^b^c), pulse start one cycle.
   - stim steps 0..7, four cycles each; busy high 32 cycles.
   - done pulses once at edge 32; table_out=8'h96, err_count=0, pass=1, first_err=0.
2. Same parameters, DUT = majority.
   - table_out=8'hE8, err_count=6 (mismatch mask 8'h7E), first_err=1, pass=0.
3. start pulsed again at cycle 10 of a running sweep.
   - Ignored: done still pulses exactly once, at edge 32; the second sweep starts only if start is high in IDLE.
4. rst_n driven low at cycle 13 of a sweep, then released.
   - All outputs return to reset values asynchronously, with no done pulse; a fresh start then completes with the scenario-1 results.
5. HOLD=1, start held high for 25 cycles, XOR DUT.
   - Sweeps run 8 RUN + 1 DONE + 1 IDLE cycles each.
   - done pulses at edges 8, 18 and 28 after the first accept; pass=1 after each.
6. DUT output stuck at 1.
   - table_out=8'hFF, err_count=4, first_err=0, pass=0.
